wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/load_align.sv | 62 ++++++
 rtl/wb_stage.sv | 118 +++++++++++
 tb/tb_wb_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared load-type codes, byte-lane constants and writeback stage fields
//
// Purpose: the load-type encoding used by the MEM stage and the writeback stage,
// plus the lane geometry of a little-endian 32-bit data word.
package mips_pkg;

  // Load-type codes as driven on in_load_type; codes 5-7 are reserved and act as LW.
  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Byte-lane offsets within a word (alu_result[1:0]).
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  // Offset bit that selects the upper halfword.
  localparam int HALF_SEL_BIT = 1;

  // Fields held by the writeback stage register.
  typedef struct packed {
    logic              wen;
    logic [4:0]        waddr;
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] mem_rdata;
    logic              is_load;
    logic [2:0]        load_type;
    logic [WORD_W-1:0] pc;
  } wb_fields_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load data extraction, extension and alignment check
//
// Purpose: picks the addressed byte/halfword out of an aligned memory word and
// sign- or zero-extends it; flags accesses whose offset is illegal for the size.
// Ports:
//   rdata      in  32  aligned word from data memory
//   offset     in  2   byte offset (effective address [1:0])
//   load_type  in  3   load-type code (mips_pkg::load_type_e)
//   data       out 32  extracted, extended load value
//   misaligned out 1   offset illegal for the access size
module load_align
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        load_type,
  output logic [WORD_W-1:0] data,
  output logic              misaligned
);

  logic [BYTE_W-1:0] byte_val;
  logic [HALF_W-1:0] half_val;

  always_comb begin
    case (offset)
      LANE_B0: byte_val = rdata[7:0];
      LANE_B1: byte_val = rdata[15:8];
      LANE_B2: byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
    half_val = offset[HALF_SEL_BIT] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    // Word access (LW and reserved codes) is the default.
    data       = rdata;
    misaligned = (offset != LANE_B0);
    case (load_type)
      LT_LB: begin
        data       = {{(WORD_W-BYTE_W){byte_val[BYTE_W-1]}}, byte_val};
        misaligned = 1'b0;
      end
      LT_LBU: begin
        data       = {{(WORD_W-BYTE_W){1'b0}}, byte_val};
        misaligned = 1'b0;
      end
      LT_LH: begin
        data       = {{(WORD_W-HALF_W){half_val[HALF_W-1]}}, half_val};
        misaligned = offset[0];
      end
      LT_LHU: begin
        data       = {{(WORD_W-HALF_W){1'b0}}, half_val};
        misaligned = offset[0];
      end
      default: begin
        data       = rdata;
        misaligned = (offset != LANE_B0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback pipeline stage with load alignment, forwarding and retire count
//
// Purpose: single-entry stage register between MEM and the register file.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             handshake from MEM (in_ready combinational)
//   in_wen, in_waddr              GPR write enable and destination
//   in_alu_result, in_mem_rdata   ALU result / load address, aligned load word
//   in_is_load, in_load_type      load flag and type code
//   in_pc                         instruction PC
//   wb_hold                       freeze writeback
//   rf_we, rf_waddr, rf_wdata     register file write port
//   fwd_valid, fwd_addr, fwd_data forwarding bus to EX
//   retire_valid, retire_pc       registered retire pulse and PC
//   addr_err                      registered pulse on misaligned load retire
//   retire_cnt                    retired-instruction count (wraps)
module wb_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wen,
  input  logic [4:0]       in_waddr,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_rdata,
  input  logic             in_is_load,
  input  logic [2:0]       in_load_type,
  input  logic [31:0]      in_pc,
  input  logic             wb_hold,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_addr,
  output logic [31:0]      fwd_data,
  output logic             retire_valid,
  output logic [31:0]      retire_pc,
  output logic             addr_err,
  output logic [CNT_W-1:0] retire_cnt
);

  wb_fields_t  wb_q;
  logic        wb_valid;
  logic        accept;
  logic        retiring;
  logic        la_misaligned;
  logic        misaligned;
  logic        writes_gpr;
  logic [31:0] load_data;
  logic [31:0] wdata;

  // The stage can take a new instruction whenever the current one leaves this cycle.
  assign in_ready = !wb_valid || !wb_hold;
  assign accept   = in_valid && in_ready;
  assign retiring = wb_valid && !wb_hold && !rst;

  load_align u_load_align (
    .rdata      (wb_q.mem_rdata),
    .offset     (wb_q.alu_result[1:0]),
    .load_type  (wb_q.load_type),
    .data       (load_data),
    .misaligned (la_misaligned)
  );

  assign misaligned = wb_q.is_load && la_misaligned;
  assign wdata      = wb_q.is_load ? load_data : wb_q.alu_result;

  // Forwarding stays live while held so EX keeps seeing the pending result.
  assign writes_gpr = wb_valid && wb_q.wen && (wb_q.waddr != 5'd0) && !misaligned && !rst;

  assign rf_we     = writes_gpr && !wb_hold;
  assign rf_waddr  = wb_q.waddr;
  assign rf_wdata  = wdata;
  assign fwd_valid = writes_gpr;
  assign fwd_addr  = wb_q.waddr;
  assign fwd_data  = wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      retire_valid <= 1'b0;
      addr_err     <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      retire_valid <= retiring;
      addr_err     <= retiring && misaligned;
      if (retiring) begin
        retire_cnt <= retire_cnt + 1'b1;
      end
      if (accept) begin
        wb_valid <= 1'b1;
      end else if (retiring) begin
        wb_valid <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only observed qualified by wb_valid / retire_valid.
  always_ff @(posedge clk) begin
    if (retiring) begin
      retire_pc <= wb_q.pc;
    end
    if (accept) begin
      wb_q.wen        <= in_wen;
      wb_q.waddr      <= in_waddr;
      wb_q.alu_result <= in_alu_result;
      wb_q.mem_rdata  <= in_mem_rdata;
      wb_q.is_load    <= in_is_load;
      wb_q.load_type  <= in_load_type;
      wb_q.pc         <= in_pc;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a behavioural writeback model
module tb_wb_stage;
  import mips_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_wen;
  logic [4:0]       in_waddr;
  logic [31:0]      in_alu_result;
  logic [31:0]      in_mem_rdata;
  logic             in_is_load;
  logic [2:0]       in_load_type;
  logic [31:0]      in_pc;
  logic             wb_hold;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             fwd_valid;
  logic [4:0]       fwd_addr;
  logic [31:0]      fwd_data;
  logic             retire_valid;
  logic [31:0]      retire_pc;
  logic             addr_err;
  logic [CNT_W-1:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an occupied/empty slot plus the values the pulses should show next cycle.
  logic             m_valid = 1'b0;
  logic             m_wen   = 1'b0;
  logic [4:0]       m_waddr = '0;
  logic [31:0]      m_data  = '0;
  logic             m_mis   = 1'b0;
  logic [31:0]      m_pc    = '0;
  logic             m_rv    = 1'b0;
  logic             m_ae    = 1'b0;
  logic [31:0]      m_rpc   = '0;
  logic [CNT_W-1:0] m_cnt   = '0;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_waddr(in_waddr), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_is_load(in_is_load), .in_load_type(in_load_type), .in_pc(in_pc), .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .addr_err(addr_err), .retire_cnt(retire_cnt)
  );

  // Load result from byte arithmetic on the little-endian word.
  function automatic void ref_wb(input logic [31:0] alu, input logic [31:0] rdata,
                                 input logic is_load, input logic [2:0] lt,
                                 output logic [31:0] d, output logic mis);
    int unsigned off, b, h;
    off = alu % 4;
    b   = (rdata / (32'd1 << (8 * off))) % 256;
    h   = (rdata / (32'd1 << (16 * (off / 2)))) % 65536;
    d   = alu;
    mis = 1'b0;
    if (is_load) begin
      if (lt == 3'd1) d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      else if (lt == 3'd2) d = b;
      else if (lt == 3'd3 || lt == 3'd4) begin
        mis = (off % 2) != 0;
        d   = (lt == 3'd3 && h >= 32768) ? h + 32'hFFFF_0000 : h;
      end else begin
        mis = (off != 0);
        d   = rdata;
      end
    end
  endfunction

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    logic acc, ret;
    acc = in_valid && (!m_valid || !wb_hold);
    ret = m_valid && !wb_hold;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_rv = 1'b0; m_ae = 1'b0; m_cnt = '0;
    end else begin
      m_rv = ret;
      m_ae = ret && m_mis;
      if (ret) begin
        m_rpc = m_pc;
        m_cnt = m_cnt + 1'b1;
      end
      if (acc) begin
        m_valid = 1'b1; m_wen = in_wen; m_waddr = in_waddr; m_pc = in_pc;
        ref_wb(in_alu_result, in_mem_rdata, in_is_load, in_load_type, m_data, m_mis);
      end else if (ret) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_in(input logic wen, input logic [4:0] waddr, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic is_load, input logic [2:0] lt,
                        input logic [31:0] pc);
    in_valid = 1'b1; in_wen = wen; in_waddr = waddr; in_alu_result = alu;
    in_mem_rdata = rdata; in_is_load = is_load; in_load_type = lt; in_pc = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_hold = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    n_checks++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_valid got %0b want 0", fwd_valid); end
    n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_retire_valid got %0b want 0", retire_valid); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %0b want 0", addr_err); end
    n_checks++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL reset_retire_cnt got %0d want 0", retire_cnt); end
  endtask

  task automatic test_add();
    set_in(1'b1, 5'd5, 32'h1234_5678, 32'h0, 1'b0, 3'd0, 32'h100);
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL add_rf_we got %0b want 1", rf_we); end
    n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL add_rf_waddr got %0d want 5", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL add_rf_wdata got %h want 12345678", rf_wdata); end
    n_checks++; if (fwd_valid !== 1'b1 || fwd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL add_fwd got %0b/%h want 1/12345678", fwd_valid, fwd_data); end
    tick();
    n_checks++; if (retire_valid !== 1'b1 || retire_pc !== 32'h100) begin n_fail++; $display("FAIL add_retire got %0b/%h want 1/00000100", retire_valid, retire_pc); end
    n_checks++; if (retire_cnt !== 4'd1) begin n_fail++; $display("FAIL add_retire_cnt got %0d want 1", retire_cnt); end
  endtask

  task automatic test_loads();
    logic [2:0]  lt_tab  [3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] alu_tab [3] = '{32'h1003, 32'h1003, 32'h1002};
    logic [31:0] exp_tab [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'd7, alu_tab[i], 32'h80FF_7F01, 1'b1, lt_tab[i], 32'h200 + i);
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++; if (rf_we !== 1'b1 || rf_wdata !== exp_tab[i]) begin n_fail++; $display("FAIL load_%0d got we=%0b data=%h want we=1 data=%h", i, rf_we, rf_wdata, exp_tab[i]); end
      tick();
    end
  endtask

  task automatic test_misaligned();
    logic [CNT_W-1:0] base;
    base = m_cnt;
    set_in(1'b1, 5'd8, 32'h2001, 32'hAABB_CCDD, 1'b1, 3'd0, 32'h240);
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL mis_we got we=%0b fwd=%0b want 0/0", rf_we, fwd_valid); end
    tick();
    n_checks++; if (addr_err !== 1'b1 || retire_valid !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got err=%0b rv=%0b want 1/1", addr_err, retire_valid); end
    n_checks++; if (retire_cnt !== CNT_W'(base + 1'b1)) begin n_fail++; $display("FAIL mis_cnt got %0d want %0d", retire_cnt, CNT_W'(base + 1'b1)); end
    tick();
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_len got %0b want 0", addr_err); end
  endtask

  task automatic test_r0();
    set_in(1'b1, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 3'd0, 32'h280);
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL r0_we got we=%0b fwd=%0b want 0/0", rf_we, fwd_valid); end
    tick();
    n_checks++; if (retire_valid !== 1'b1) begin n_fail++; $display("FAIL r0_retire got %0b want 1", retire_valid); end
  endtask

  task automatic test_hold();
    set_in(1'b1, 5'd9, 32'h0000_CAFE, 32'h0, 1'b0, 3'd0, 32'h300);
    tick();
    in_valid = 1'b0;
    wb_hold  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL hold_%0d_ready_we got %0b/%0b want 0/0", i, in_ready, rf_we); end
      n_checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd9 || fwd_data !== 32'h0000_CAFE) begin n_fail++; $display("FAIL hold_%0d_fwd got %0b/%0d/%h want 1/9/0000cafe", i, fwd_valid, fwd_addr, fwd_data); end
      tick();
      n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL hold_%0d_retire got %0b want 0", i, retire_valid); end
    end
    wb_hold = 1'b0;
    set_in(1'b1, 5'd10, 32'h0000_0055, 32'h0, 1'b0, 3'd0, 32'h304);
    #1;
    n_checks++; if (in_ready !== 1'b1 || rf_we !== 1'b1 || rf_wdata !== 32'h0000_CAFE) begin n_fail++; $display("FAIL release got ready=%0b we=%0b data=%h want 1/1/0000cafe", in_ready, rf_we, rf_wdata); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (retire_valid !== 1'b1 || retire_pc !== 32'h300) begin n_fail++; $display("FAIL release_retire got %0b/%h want 1/00000300", retire_valid, retire_pc); end
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10) begin n_fail++; $display("FAIL release_next got %0b/%0d want 1/10", rf_we, rf_waddr); end
    tick();
    n_checks++; if (retire_cnt !== m_cnt) begin n_fail++; $display("FAIL hold_cnt got %0d want %0d", retire_cnt, m_cnt); end
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] vals [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_in(1'b1, 5'(i + 1), vals[i], 32'h0, 1'b0, 3'd0, 32'h400 + 32'(4 * i));
      else in_valid = 1'b0;
      #1;
      if (i > 0) begin
        n_checks++; if (rf_we !== 1'b1 || rf_wdata !== vals[i-1]) begin n_fail++; $display("FAIL b2b_%0d_write got %0b/%h want 1/%h", i, rf_we, rf_wdata, vals[i-1]); end
      end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_%0d_ready got %0b want 1", i, in_ready); end
      tick();
      if (i > 0) begin
        n_checks++; if (retire_valid !== 1'b1 || retire_pc !== 32'h400 + 32'(4 * (i - 1))) begin n_fail++; $display("FAIL b2b_%0d_retire got %0b/%h want 1/%h", i, retire_valid, retire_pc, 32'h400 + 32'(4 * (i - 1))); end
      end
    end
    set_in(1'b1, 5'd20, 32'h5555_AAAA, 32'h0, 1'b0, 3'd0, 32'h500);
    tick();
    in_valid = 1'b0;
    wb_hold  = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_hold_we got %0b want 0", rf_we); end
    tick();
    rst = 1'b0;
    wb_hold = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || rf_we !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after got ready=%0b we=%0b fwd=%0b want 1/0/0", in_ready, rf_we, fwd_valid); end
    n_checks++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", retire_cnt); end
    tick();
    n_checks++; if (retire_valid !== 1'b0 || retire_cnt !== '0) begin n_fail++; $display("FAIL rst_dropped got rv=%0b cnt=%0d want 0/0", retire_valid, retire_cnt); end
  endtask

  task automatic test_random();
    logic exp_fwd, exp_we;
    for (int c = 0; c < 400; c++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      wb_hold       = ($urandom_range(0, 3) == 0);
      in_wen        = ($urandom_range(0, 7) != 0);
      in_waddr      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_alu_result = $urandom;
      in_mem_rdata  = $urandom;
      in_is_load    = 1'($urandom_range(0, 1));
      in_load_type  = 3'($urandom_range(0, 7));
      in_pc         = $urandom;
      #1;
      exp_fwd = m_valid && m_wen && (m_waddr != 5'd0) && !m_mis;
      exp_we  = exp_fwd && !wb_hold;
      n_checks++; if (in_ready !== (!m_valid || !wb_hold)) begin n_fail++; $display("FAIL rnd_%0d_ready got %0b want %0b", c, in_ready, !m_valid || !wb_hold); end
      n_checks++; if (rf_we !== exp_we || fwd_valid !== exp_fwd) begin n_fail++; $display("FAIL rnd_%0d_we_fwd got %0b/%0b want %0b/%0b", c, rf_we, fwd_valid, exp_we, exp_fwd); end
      if (exp_fwd) begin
        n_checks++; if (rf_waddr !== m_waddr || rf_wdata !== m_data || fwd_addr !== m_waddr || fwd_data !== m_data) begin n_fail++; $display("FAIL rnd_%0d_data got %0d/%h want %0d/%h", c, rf_waddr, rf_wdata, m_waddr, m_data); end
      end
      n_checks++; if (retire_valid !== m_rv || addr_err !== m_ae) begin n_fail++; $display("FAIL rnd_%0d_pulses got rv=%0b err=%0b want %0b/%0b", c, retire_valid, addr_err, m_rv, m_ae); end
      if (m_rv) begin
        n_checks++; if (retire_pc !== m_rpc) begin n_fail++; $display("FAIL rnd_%0d_pc got %h want %h", c, retire_pc, m_rpc); end
      end
      n_checks++; if (retire_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_%0d_cnt got %0d want %0d", c, retire_cnt, m_cnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_loads();
    test_misaligned();
    test_r0();
    test_hold();
    test_back_to_back_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
